// File: rtl/fetch_buf.sv
// fetch_buf: fully-associative instruction line buffer with a single outstanding miss.
// Define FETCH_BUF_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
package fetch_buf_pkg;
    typedef logic [31:0] t_paddr;
    typedef struct packed {
        logic       valid;
        t_paddr     addr;
        logic [3:0] id;
    } t_fe_fb_req;
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        t_paddr      pc;
    } t_fb_fe_rsp;
    typedef struct packed {
        logic valid;
    } t_nuke_pkt;
    typedef struct packed {
        logic valid;
    } t_br_mispred_pkt;
endpackage

module fetch_buf
    import fetch_buf_pkg::*;
#(
    parameter int NUM_LINES  = 2,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
`ifdef FETCH_BUF_PERF_CNT_EN
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt,
`endif
    input  t_fe_fb_req              fe_fb_req_nnn,
    output t_fb_fe_rsp              fb_fe_rsp_nnn,
    input  t_nuke_pkt               nuke_rb1,
    input  t_br_mispred_pkt         br_mispred_ex0,
    output logic                    fb_mem_req_valid,
    output t_paddr                  fb_mem_req_addr,
    input  logic                    mem_fb_req_ready,
    input  logic                    mem_fb_rsp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_fb_rsp_data
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = 32 - OFF_W;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [2:0] {FB_IDLE, FB_HIT, FB_MISS_REQ, FB_MISS_PDG, FB_FILL_RSP} t_state;

    t_state                  state_q, state_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [NUM_LINES];
    logic [LINE_BYTES*8-1:0] data_q [NUM_LINES];
    logic [IDX_W-1:0]        rr_q, rr_d, sel_q, sel_d, hit_idx, victim;
    logic                    drop_q, drop_d, hit, flush, accept, fill, rsp_valid;
    t_paddr                  addr_q;
    logic [3:0]              id_q;
    logic [TAG_W-1:0]        req_tag;
    logic [WSEL_W-1:0]       wsel;
    logic [31:0]             instr;
    logic                    unused_id;

    assign flush   = nuke_rb1.valid | br_mispred_ex0.valid;
    assign accept  = (state_q == FB_IDLE) && fe_fb_req_nnn.valid;
    assign fill    = (state_q == FB_MISS_PDG) && mem_fb_rsp_valid;
    assign req_tag = fe_fb_req_nnn.addr[31:OFF_W];
    assign wsel    = addr_q[OFF_W-1:2];
    assign instr   = data_q[sel_q][{wsel, 5'd0} +: 32];
    assign unused_id = ^id_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++)
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
    end

    // Lowest-index invalid entry wins; only a full buffer falls back to round-robin.
    always_comb begin
        victim = rr_q;
        for (int i = NUM_LINES - 1; i >= 0; i--)
            if (!valid_q[i]) victim = IDX_W'(i);
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            FB_IDLE: if (fe_fb_req_nnn.valid) state_d = hit ? FB_HIT : FB_MISS_REQ;
            FB_HIT, FB_FILL_RSP: state_d = FB_IDLE;
            FB_MISS_REQ: begin
                state_d = mem_fb_req_ready ? FB_MISS_PDG : flush ? FB_IDLE : FB_MISS_REQ;
                drop_d  = mem_fb_req_ready & flush;
            end
            FB_MISS_PDG: begin
                drop_d  = mem_fb_rsp_valid ? 1'b0 : drop_q | flush;
                state_d = !mem_fb_rsp_valid ? FB_MISS_PDG : (drop_q | flush) ? FB_IDLE : FB_FILL_RSP;
            end
            default: state_d = FB_IDLE;
        endcase
    end

    assign valid_d = fill ? valid_q | (NUM_LINES'(1) << victim) : valid_q;
    assign rr_d    = (fill && &valid_q) ? rr_q + 1'b1 : rr_q;
    assign sel_d   = accept ? hit_idx : fill ? victim : sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FB_IDLE;
            valid_q <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= fe_fb_req_nnn.addr;
            id_q   <= fe_fb_req_nnn.id;
        end
        if (fill) begin
            tag_q[victim]  <= addr_q[31:OFF_W];
            data_q[victim] <= mem_fb_rsp_data;
        end
    end

    assign rsp_valid        = (state_q == FB_HIT || state_q == FB_FILL_RSP) && !flush;
    assign fb_fe_rsp_nnn    = rsp_valid ? {1'b1, instr, addr_q} : '0;
    assign fb_mem_req_valid = state_q == FB_MISS_REQ;
    assign fb_mem_req_addr  = fb_mem_req_valid ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;

`ifdef FETCH_BUF_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept && hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (accept && !hit && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    // Requests are only legal while idle; anything else is dropped by the FSM.
    a_req_only_idle: assert property (@(posedge clk) disable iff (!reset_n)
        !(fe_fb_req_nnn.valid && state_q != FB_IDLE));
endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 SHALL have parameter NUM_LINES, default 2, number of fully-associative line entries (power of two, 2..8).
REQ-002 SHALL have parameter LINE_BYTES, default 16, bytes per line (four 32-bit instructions).
REQ-003 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fe_fb_req_nnn  input  t_fe_fb_req  fetch request: valid, addr, id.
REQ-006 SHALL have port fb_fe_rsp_nnn  output  t_fb_fe_rsp  fetch response: valid, instr, pc.
REQ-007 SHALL have port nuke_rb1  input  t_nuke_pkt  pipeline nuke; only .valid is used.
REQ-008 SHALL have port br_mispred_ex0  input  t_br_mispred_pkt  redirect; only .valid is used.
REQ-009 SHALL have port fb_mem_req_valid  output  1  line fill request valid.
REQ-010 SHALL have port fb_mem_req_addr  output  t_paddr  line-aligned fill address.
REQ-011 SHALL have port mem_fb_req_ready  input  1  memory accepts the fill request.
REQ-012 SHALL have port mem_fb_rsp_valid  input  1  fill data valid, one-cycle pulse.
REQ-013 SHALL have port mem_fb_rsp_data  input  LINE_BYTES*8  fill line data, byte 0 in bits [7:0].

Function
REQ-014 SHALL hold per entry: valid bit, line tag (addr without offset bits), line data.
REQ-015 SHALL implement FSM states FB_IDLE, FB_HIT, FB_MISS_REQ, FB_MISS_PDG, FB_FILL_RSP.
REQ-016 In FB_IDLE, a request whose line tag matches a valid entry SHALL transition to FB_HIT; a mismatch SHALL transition to FB_MISS_REQ; the request addr and id are captured.
REQ-017 In FB_HIT, fb_fe_rsp_nnn.valid SHALL be 1 for exactly one cycle, carrying the selected 32-bit word and pc equal to the captured addr; next state FB_IDLE (hit latency: 1 cycle after request).
REQ-018 In FB_MISS_REQ, fb_mem_req_valid SHALL be 1 with addr = captured addr with offset bits zeroed, and SHALL hold until mem_fb_req_ready; ready transitions to FB_MISS_PDG.
REQ-019 In FB_MISS_PDG, mem_fb_rsp_valid SHALL write the line into the victim entry (first invalid entry, lowest index first, else round-robin pointer) and transition to FB_FILL_RSP.
REQ-020 In FB_FILL_RSP, the response SHALL be driven as in REQ-017 from the filled entry; next state FB_IDLE.
REQ-021 The round-robin pointer SHALL advance by one, modulo NUM_LINES, only on a fill into a full buffer.
REQ-022 A request arriving in any state other than FB_IDLE is a protocol violation; it SHALL be ignored and flagged by an assertion.
REQ-023 Flush = nuke_rb1.valid | br_mispred_ex0.valid.
REQ-024 Flush in FB_HIT or FB_FILL_RSP SHALL suppress fb_fe_rsp_nnn.valid that cycle; next state FB_IDLE.
REQ-025 Flush in FB_MISS_REQ before ready SHALL drop the request (valid low next cycle); next state FB_IDLE. Flush coincident with ready SHALL behave as flush in FB_MISS_PDG.
REQ-026 Flush in FB_MISS_PDG SHALL set a drop flag; the fill SHALL still be written, no response is sent, and the FSM returns to FB_IDLE; requests are not accepted until then.
REQ-027 A flush coincident with a new request in FB_IDLE SHALL accept the request.
REQ-028 Flush SHALL NOT invalidate line entries.
REQ-029 Word select SHALL be addr[log2(LINE_BYTES)-1:2]; addr[1:0] are ignored.

Reset
REQ-030 While reset_n is low: state FB_IDLE, all entry valid bits 0, round-robin pointer 0, drop flag 0, fb_fe_rsp_nnn all zero, fb_mem_req_valid 0.
REQ-031 Reset asserted mid-miss SHALL abandon the fill; a later mem_fb_rsp_valid in FB_IDLE SHALL be ignored.

Configuration
REQ-032 With FETCH_BUF_PERF_CNT_EN defined, the block SHALL add 32-bit outputs hit_cnt and miss_cnt, reset to 0, incrementing on FB_IDLE→FB_HIT and FB_IDLE→FB_MISS_REQ, and saturating at all-ones.
REQ-033 Without FETCH_BUF_PERF_CNT_EN, those ports and counters SHALL NOT exist, and behaviour is otherwise identical.

Verification
REQ-034 Cold miss: req addr 0x100, ready same cycle, fill 3 cycles later with words {A,B,C,D} -> one fill req at 0x100, one rsp with instr A, pc 0x100.
REQ-035 Hit: after REQ-034, req 0x108 -> rsp with instr C, pc 0x108, exactly 1 cycle later, no mem request.
REQ-036 Replacement: NUM_LINES=2, fill 0x100, then 0x200, then 0x300 -> 0x300 replaces entry 0; a following req 0x104 misses and 0x204 hits.
REQ-037 Flush in pending state: miss on 0x400, nuke while in FB_MISS_PDG, fill arrives -> no rsp; a following req 0x404 hits.
REQ-038 Ready backpressure: req 0x500 with ready held low 5 cycles -> fb_mem_req_valid held for 6 cycles with constant addr 0x500.
REQ-039 Reset mid-miss: reset_n low in FB_MISS_PDG, then late fill pulse -> all outputs 0, and req 0x100 misses; with FETCH_BUF_PERF_CNT_EN, hit_cnt=0 and miss_cnt=1.
